pipe_adder: RTL and testbench

Parametrised pipelined adder/subtractor: the sequential successor to the team's 32-bit combinational `adder`. Splits the carry chain into `STAGES` equal segments, one per register stage, and accepts one operation per cycle. A valid/ready handshake on both sides allows back-pressure. Sits between an operand source (register file, ALU issue, or testbench driver) and a result consumer, with in-order results.

---
 rtl/pipe_adder_if.sv | 37 +++
 rtl/pipe_adder.sv | 125 ++++++++++++
 tb/tb_pipe_adder.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder. The overflow signal and its
// modport entries exist only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             overflow;

    modport master (
        output in_valid, operand1, operand2, cin, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow
    );
    modport slave (
        input  in_valid, operand1, operand2, cin, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow
    );
`else
    modport master (
        output in_valid, operand1, operand2, cin, sub, out_ready,
        input  in_ready, out_valid, result, cout
    );
    modport slave (
        input  in_valid, operand1, operand2, cin, sub, out_ready,
        output in_ready, out_valid, result, cout
    );
`endif
endinterface

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal segments,
// one per register stage, with valid/ready back-pressure. Optional signed
// overflow output is enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic       clk,
    input  logic       resetn,
    pipe_adder_if.slave bus
);
    localparam int STG_SAFE = (STAGES > 0) ? STAGES : 1;
    localparam int SEG      = WIDTH / STG_SAFE;

    genvar gi;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STG_SAFE) != 0) begin : g_bad_cfg
        $error("pipe_adder: STAGES=%0d is not legal for WIDTH=%0d", STAGES, WIDTH);
    end

    // Index k of each array is the input seen by stage k; index k+1 is its register.
    logic             v_s [STAGES+1];
    logic [WIDTH-1:0] a_s [STAGES];
    logic [WIDTH-1:0] b_s [STAGES];
    logic [WIDTH-1:0] r_s [STAGES+1];
    logic             c_s [STAGES+1];
    logic             advance;

    assign advance = !v_s[STAGES] || bus.out_ready;

    // Subtraction is folded in once at entry: a + ~b + !cin.
    assign v_s[0] = bus.in_valid;
    assign a_s[0] = bus.operand1;
    assign b_s[0] = bus.sub ? ~bus.operand2 : bus.operand2;
    assign c_s[0] = bus.sub ? ~bus.cin : bus.cin;
    assign r_s[0] = '0;

    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [SEG:0]     seg_sum;
        logic [WIDTH-1:0] r_d;
        logic             load;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] r_q;

        assign seg_sum = {1'b0, a_s[gi][gi*SEG +: SEG]}
                       + {1'b0, b_s[gi][gi*SEG +: SEG]}
                       + {{SEG{1'b0}}, c_s[gi]};

        always_comb begin
            r_d = r_s[gi];
            r_d[gi*SEG +: SEG] = seg_sum[SEG-1:0];
        end

        // Data only loads with a real op, so bubbles leave the last result visible.
        assign load = advance && v_s[gi];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else begin
                if (advance) begin
                    v_q <= v_s[gi];
                end
                if (load) begin
                    c_q <= seg_sum[SEG];
                    r_q <= r_d;
                end
            end
        end

        assign v_s[gi+1] = v_q;
        assign c_s[gi+1] = c_q;
        assign r_s[gi+1] = r_q;

        if (gi < STAGES - 1) begin : g_operands
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= a_s[gi];
                    b_q <= b_s[gi];
                end
            end

            assign a_s[gi+1] = a_q;
            assign b_s[gi+1] = b_q;
        end

`ifdef PIPE_ADDER_OVF_EN
        if (gi == STAGES - 1) begin : g_overflow
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            assign ovf_d = (a_s[gi][WIDTH-1] ^ b_s[gi][WIDTH-1] ^ seg_sum[SEG-1]) ^ seg_sum[SEG];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    ovf_q <= 1'b0;
                end else if (load) begin
                    ovf_q <= ovf_d;
                end
            end

            assign bus.overflow = ovf_q;
        end
`endif
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = v_s[STAGES];
    assign bus.result    = r_s[STAGES];
    assign bus.cout      = c_s[STAGES];

    a_hold_stable: assert property (@(posedge clk) disable iff (!resetn)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.result) && $stable(bus.cout)));

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed checks on a 4-stage instance plus randomized
// handshake traffic on 1/2/8/32-stage instances against an arithmetic model.
module tb_pipe_adder;
    localparam int N_RAND   = 2500;
    localparam int RAND_MAX = 30000;

    logic clk;
    logic resetn;
    int   n_vec;
    int   n_err;
    bit   rand_go;
    bit   var_fin [4];
    int   mout;

    pipe_adder_if #(.WIDTH(32)) m();
    pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut (.clk(clk), .resetn(resetn), .bus(m));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic. Returns {overflow, cout, result}.
    function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic c, input logic s);
        longint ua, ub, cc, sa, sb, r, sr;
        logic   co, ov;
        ua = longint'(a);
        ub = longint'(b);
        cc = c ? 64'sd1 : 64'sd0;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        if (!s) begin
            r  = ua + ub + cc;
            sr = sa + sb + cc;
            co = (r > 64'sd4294967295);
        end else begin
            r  = ua - ub - cc;
            sr = sa - sb - cc;
            co = (r >= 64'sd0);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {ov, co, r[31:0]};
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(7, 0))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard for the 4-stage instance.
    logic [33:0] mq [$];
    bit          stall_q;
    logic [31:0] held_r;
    logic        held_c;

    always begin
        @(negedge clk);
        #2;
        if (!resetn) begin
            mq.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check_eq("hold_result", {32'h0, m.result}, {32'h0, held_r});
                check_eq("hold_cout", {63'h0, m.cout}, {63'h0, held_c});
            end
            if (m.in_valid && m.in_ready)
                mq.push_back(ref_op(m.operand1, m.operand2, m.cin, m.sub));
            if (m.out_valid && m.out_ready) begin
                if (mq.size() == 0) begin
                    check_eq("main_stale", 64'd1, 64'd0);
                end else begin
                    logic [33:0] e;
                    e = mq.pop_front();
                    check_eq("main_result", {32'h0, m.result}, {32'h0, e[31:0]});
                    check_eq("main_cout", {63'h0, m.cout}, {63'h0, e[32]});
`ifdef PIPE_ADDER_OVF_EN
                    check_eq("main_ovf", {63'h0, m.overflow}, {63'h0, e[33]});
`endif
                    $display("s4 out #%0d: result=%h cout=%b (model %h/%b)", mout, m.result, m.cout, e[31:0], e[32]);
                end
                mout++;
            end
            stall_q = m.out_valid && !m.out_ready;
            held_r  = m.result;
            held_c  = m.cout;
        end
    end

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
        m.operand1 = a;
        m.operand2 = b;
        m.cin      = c;
        m.sub      = s;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
        int t;
        @(negedge clk);
        m.in_valid = 1'b1;
        set_op(a, b, c, s);
        #1;
        t = 0;
        while (!m.in_ready && t < 64) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!m.in_ready) check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    // Single op into an empty pipe: checks latency, one-cycle valid and the values.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic c, input logic s,
                           input logic [31:0] er, input logic ec, input logic eo);
        int          first;
        int          cnt;
        logic [31:0] got_r;
        logic        got_c;
        logic        got_o;
        first = -1;
        cnt   = 0;
        got_r = '0;
        got_c = 1'b0;
        got_o = 1'b0;
        m.out_ready = 1'b1;
        send(a, b, c, s);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) m.in_valid = 1'b0;
            #3;
            if (m.out_valid) begin
                if (first < 0) begin
                    first = i;
                    got_r = m.result;
                    got_c = m.cout;
`ifdef PIPE_ADDER_OVF_EN
                    got_o = m.overflow;
`endif
                end
                cnt++;
            end
        end
        $display("%s: result=%h cout=%b ovf=%b latency=%0d (want %h/%b/%b)", tag, got_r, got_c, got_o, first, er, ec, eo);
        check_eq({tag, "_latency"}, 64'(first), 64'd4);
        check_eq({tag, "_vcycles"}, 64'(cnt), 64'd1);
        check_eq({tag, "_result"}, {32'h0, got_r}, {32'h0, er});
        check_eq({tag, "_cout"}, {63'h0, got_c}, {63'h0, ec});
`ifdef PIPE_ADDER_OVF_EN
        check_eq({tag, "_ovf"}, {63'h0, got_o}, {63'h0, eo});
`endif
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            m.in_valid = 1'b0;
        end
    endtask

    // Randomized traffic on other depths.
    for (genvar gi = 0; gi < 4; gi++) begin : g_var
        localparam int ST = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 32;

        pipe_adder_if #(.WIDTH(32)) v();
        pipe_adder #(.WIDTH(32), .STAGES(ST)) u_var (.clk(clk), .resetn(resetn), .bus(v));

        logic [33:0] q [$];

        initial begin
            int          sent;
            int          got;
            int          cyc;
            bit          taken;
            logic [33:0] e;
            v.in_valid  = 1'b0;
            v.out_ready = 1'b0;
            v.operand1  = '0;
            v.operand2  = '0;
            v.cin       = 1'b0;
            v.sub       = 1'b0;
            sent  = 0;
            got   = 0;
            cyc   = 0;
            taken = 1'b0;
            wait (rand_go);
            while (got < N_RAND && cyc < RAND_MAX) begin
                @(negedge clk);
                cyc++;
                if (!v.in_valid || taken) begin
                    v.in_valid = (sent < N_RAND) && ($urandom_range(1, 0) == 1);
                    v.operand1 = rand_word();
                    v.operand2 = rand_word();
                    v.cin      = 1'($urandom_range(1, 0));
                    v.sub      = 1'($urandom_range(1, 0));
                end
                v.out_ready = 1'($urandom_range(1, 0));
                #1;
                taken = v.in_valid && v.in_ready;
                if (taken) begin
                    q.push_back(ref_op(v.operand1, v.operand2, v.cin, v.sub));
                    sent++;
                end
                if (v.out_valid && v.out_ready) begin
                    if (q.size() == 0) begin
                        check_eq($sformatf("s%0d_stale", ST), 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        check_eq($sformatf("s%0d_result", ST), {32'h0, v.result}, {32'h0, e[31:0]});
                        check_eq($sformatf("s%0d_cout", ST), {63'h0, v.cout}, {63'h0, e[32]});
`ifdef PIPE_ADDER_OVF_EN
                        check_eq($sformatf("s%0d_ovf", ST), {63'h0, v.overflow}, {63'h0, e[33]});
`endif
                        $display("s%0d out #%0d: result=%h cout=%b (model %h/%b)", ST, got, v.result, v.cout, e[31:0], e[32]);
                    end
                    got++;
                end
            end
            check_eq($sformatf("s%0d_count", ST), 64'(got), 64'(N_RAND));
            v.in_valid = 1'b0;
            var_fin[gi] = 1'b1;
        end
    end

    initial begin
        int          first;
        int          last;
        int          cnt;
        int          sent;
        int          base;
        bit          acc;
        logic [31:0] held;
        n_vec = 0;
        n_err = 0;
        mout  = 0;
        rand_go = 1'b0;
        resetn = 1'b0;
        m.in_valid  = 1'b0;
        m.out_ready = 1'b0;
        set_op('0, '0, 1'b0, 1'b0);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_out_valid", {63'h0, m.out_valid}, 64'd0);
        check_eq("rst_in_ready", {63'h0, m.in_ready}, 64'd1);
        check_eq("rst_result", {32'h0, m.result}, 64'd0);
        check_eq("rst_cout", {63'h0, m.cout}, 64'd0);
`ifdef PIPE_ADDER_OVF_EN
        check_eq("rst_ovf", {63'h0, m.overflow}, 64'd0);
`endif
        @(negedge clk);
        resetn = 1'b1;

        // Directed single ops.
        run_one("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_one("add_wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_borrow_in", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Streaming: 100 back-to-back ops, consumer always ready.
        first = -1;
        last  = -1;
        cnt   = 0;
        base  = mout;
        m.out_ready = 1'b1;
        for (int i = 0; i < 108; i++) begin
            @(negedge clk);
            m.in_valid = (i < 100);
            set_op(rand_word(), rand_word(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            #3;
            if (m.out_valid) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        $display("stream: first=%0d last=%0d valid_cycles=%0d", first, last, cnt);
        check_eq("stream_first", 64'(first), 64'd4);
        check_eq("stream_count", 64'(cnt), 64'd100);
        check_eq("stream_nobubble", 64'(last - first + 1), 64'd100);
        check_eq("stream_outputs", 64'(mout - base), 64'd100);

        // Back-pressure: fill, stall 5 cycles, resume.
        base = mout;
        sent = 0;
        acc  = 1'b1;
        held = '0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            m.out_ready = !(i >= 4 && i < 9);
            if (acc || !m.in_valid) begin
                m.in_valid = (sent < 16);
                set_op(rand_word(), rand_word(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            end
            #1;
            acc = m.in_valid && m.in_ready;
            if (acc) sent++;
            if (i == 4) held = m.result;
            if (i >= 4 && i < 9) begin
                check_eq($sformatf("bp_in_ready_%0d", i), {63'h0, m.in_ready}, 64'd0);
                check_eq($sformatf("bp_out_valid_%0d", i), {63'h0, m.out_valid}, 64'd1);
                check_eq($sformatf("bp_result_%0d", i), {32'h0, m.result}, {32'h0, held});
            end
        end
        drain(8);
        #3;
        $display("backpressure: sent=%0d outputs=%0d pending=%0d", sent, mout - base, mq.size());
        check_eq("bp_sent", 64'(sent), 64'd16);
        check_eq("bp_outputs", 64'(mout - base), 64'd16);
        check_eq("bp_pending", 64'(mq.size()), 64'd0);

        // Reset with one result held at the output and three ops behind it.
        m.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m.in_valid = 1'b1;
            set_op(rand_word(), rand_word(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end
        @(negedge clk);
        m.in_valid = 1'b0;
        #1;
        check_eq("mid_out_valid_pre", {63'h0, m.out_valid}, 64'd1);
        resetn = 1'b0;
        #1;
        $display("mid-stream reset: out_valid=%b in_ready=%b result=%h", m.out_valid, m.in_ready, m.result);
        check_eq("mid_rst_out_valid", {63'h0, m.out_valid}, 64'd0);
        check_eq("mid_rst_in_ready", {63'h0, m.in_ready}, 64'd1);
        check_eq("mid_rst_result", {32'h0, m.result}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        base = mout;
        run_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        drain(6);
        #3;
        check_eq("post_rst_outputs", 64'(mout - base), 64'd1);

        // Randomized handshakes on the other depths.
        rand_go = 1'b1;
        while (!(var_fin[0] && var_fin[1] && var_fin[2] && var_fin[3])) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
